clk_manager: RTL and testbench

CLK_MANAGER -- requirements
Module: clk_manager

---
 rtl/clk_manager.sv | 133 +++++++++++++
 tb/tb_clk_manager.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/clk_manager.sv
// PLL reset/lock sequencer: releases sys_rst after a stable lock and generates per-channel divided ce strobes.
// Optional CLK_MANAGER_RELOCK_EN: re-pulse the PLL on lock loss or lock timeout, with retry limit and sticky FAULT.

module clk_manager_ch #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);
  logic [DIV_W-1:0] cnt, shadow;
  logic             hit;

  // Shadow of 0 or 1 strobes every cycle; outside RUN the channel sits at phase 0 tracking div.
  assign hit = (shadow <= DIV_W'(1)) || (cnt == shadow - DIV_W'(1));
  assign ce  = run && hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      shadow <= '0;
    end else if (!run || hit) begin
      cnt    <= '0;
      shadow <= div;
    end else begin
      cnt    <= cnt + DIV_W'(1);
    end
  end
endmodule

module clk_manager #(
  parameter int NUM_CH         = 4,
  parameter int DIV_W          = 16,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_WAIT      = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int MAX_RETRY      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div,
  output logic                    pll_rst_n,
  output logic                    sys_rst,
  output logic [NUM_CH-1:0]       ce,
  output logic                    lock_sync,
  output logic [1:0]              retry_cnt,
  output logic                    fault
);
  localparam int CMAX = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int SW   = $clog2(LOCK_WAIT) + 1;

  typedef enum logic [2:0] {PLL_RESET, WAIT_LOCK, STABLE, RUN, FAULT} state_t;

  state_t        state, nxt, lost_tgt;
  logic          sync1, cyc_en, timeout, run;
  logic [CW-1:0] cyc_cnt;
  logic [SW-1:0] stab_cnt;

`ifdef CLK_MANAGER_RELOCK_EN
  assign cyc_en   = (state == PLL_RESET) || (state == WAIT_LOCK);
  assign timeout  = (cyc_cnt == CW'(LOCK_TIMEOUT - 1));
  assign lost_tgt = (int'(retry_cnt) < MAX_RETRY) ? PLL_RESET : FAULT;

  always_ff @(posedge clk) begin
    if (reset) begin
      retry_cnt <= '0;
      fault     <= 1'b0;
    end else begin
      if (state != PLL_RESET && nxt == PLL_RESET && retry_cnt != 2'd3)
        retry_cnt <= retry_cnt + 2'd1;
      fault <= (nxt == FAULT);
    end
  end
`else
  assign cyc_en    = (state == PLL_RESET);
  assign timeout   = 1'b0;
  assign lost_tgt  = WAIT_LOCK;
  assign retry_cnt = 2'd0;
  assign fault     = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      PLL_RESET: if (cyc_cnt == CW'(PLL_RST_CYCLES - 1)) nxt = WAIT_LOCK;
      WAIT_LOCK: if (lock_sync) nxt = STABLE;
                 else if (timeout) nxt = lost_tgt;
      STABLE:    if (!lock_sync) nxt = WAIT_LOCK;
                 else if (stab_cnt == SW'(LOCK_WAIT - 1)) nxt = RUN;
      RUN:       if (!lock_sync) nxt = lost_tgt;
      default:   nxt = FAULT;
    endcase
  end

  // Outputs are registered from nxt so they change on the same edge as the state.
  // WAIT_LOCK spends one cycle seeing lock, so RUN starts LOCK_WAIT+1 cycles after WAIT_LOCK entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PLL_RESET;
      cyc_cnt   <= '0;
      stab_cnt  <= '0;
      sync1     <= 1'b0;
      lock_sync <= 1'b0;
      pll_rst_n <= 1'b0;
      sys_rst   <= 1'b1;
    end else begin
      sync1     <= pll_locked;
      lock_sync <= sync1;
      state     <= nxt;
      if (nxt != state)  cyc_cnt <= '0;
      else if (cyc_en)   cyc_cnt <= cyc_cnt + CW'(1);
      stab_cnt  <= (state == STABLE && nxt == STABLE) ? stab_cnt + SW'(1) : '0;
      pll_rst_n <= !(nxt == PLL_RESET || nxt == FAULT);
      sys_rst   <= (nxt != RUN);
    end
  end

  assign run = ~sys_rst;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_manager_ch #(.DIV_W(DIV_W)) u_ch (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .div   (div[k*DIV_W +: DIV_W]),
      .ce    (ce[k])
    );
  end
endmodule

// File: tb/tb_clk_manager.sv
// Bench for clk_manager: lock-streak based reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_clk_manager;
  localparam int NCH = 4, DW = 16, PRC = 16, LW = 1024, LTO = 100, MR = 3;

  logic              clk = 1'b0, reset = 1'b0, pll_locked = 1'b0;
  logic [NCH*DW-1:0] div = '0;
  logic              pll_rst_n, sys_rst, lock_sync, fault;
  logic [NCH-1:0]    ce;
  logic [1:0]        retry_cnt;
  int                errors = 0, checks = 0;

  always #5 clk = ~clk;

  clk_manager #(.NUM_CH(NCH), .DIV_W(DW), .PLL_RST_CYCLES(PRC), .LOCK_WAIT(LW),
                .LOCK_TIMEOUT(LTO), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .div(div),
    .pll_rst_n(pll_rst_n), .sys_rst(sys_rst), .ce(ce), .lock_sync(lock_sync),
    .retry_cnt(retry_cnt), .fault(fault));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: after the PLL pulse, RUN holds once lock_sync has been seen high LW+1 edges in a row.
  int       since, streak, wait_cnt, m_retry, rc;
  int       fire_at [NCH];
  bit       m_fault, s1, s2, armed;
  logic     e_ls, e_prst_n, e_sys_rst;
  logic [NCH-1:0] e_ce;

  function automatic int per(input int k);
    int d;
    d = int'(div[k*DW +: DW]);
    return (d < 2) ? 1 : d;
  endfunction

  always @(posedge clk) begin
    bit ls, was_run;
    ls = s2;
    if (reset) begin
      armed = 1; s1 = 0; s2 = 0; since = 0; streak = 0; wait_cnt = 0;
      m_retry = 0; m_fault = 0; rc = 0;
      for (int k = 0; k < NCH; k++) fire_at[k] = 0;
    end else begin
      s2 = s1; s1 = pll_locked;
      if (!m_fault) begin
        if (since < PRC) since++;
        else if (ls) begin
          was_run = streak > LW;
          streak++;
          wait_cnt = 0;
          if (streak == LW + 1) begin
            rc = 1;
            for (int k = 0; k < NCH; k++) fire_at[k] = per(k);
          end else if (was_run) begin
            for (int k = 0; k < NCH; k++) if (fire_at[k] == rc) fire_at[k] = rc + per(k);
            rc++;
          end
        end else begin
          was_run = streak > LW;
          if (streak == 0) wait_cnt++;
          streak = 0;
`ifdef CLK_MANAGER_RELOCK_EN
          if (was_run || wait_cnt == LTO) begin
            wait_cnt = 0;
            if (m_retry < MR) begin m_retry++; since = 0; end
            else m_fault = 1;
          end
`endif
        end
      end
    end
    e_ls      = s2;
    e_prst_n  = !m_fault && since >= PRC;
    e_sys_rst = !(!m_fault && since >= PRC && streak > LW);
    for (int k = 0; k < NCH; k++) e_ce[k] = !e_sys_rst && (fire_at[k] == rc);
  end

  always @(negedge clk) if (armed) begin
    chk("lock_sync", lock_sync, e_ls);
    chk("pll_rst_n", pll_rst_n, e_prst_n);
    chk("sys_rst",   sys_rst,   e_sys_rst);
    chk("ce",        ce,        e_ce);
    chk("retry_cnt", retry_cnt, m_retry);
    chk("fault",     fault,     m_fault);
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    reset = 1'b1; step(1); reset = 1'b0;
  endtask

  initial begin
    int n, gap, first3, c0, c1, c2, c3;
    div = {16'd10, 16'd3, 16'd1, 16'd0};
    pll_locked = 1'b1;
    do_reset();
    chk("rst_pll_rst_n", pll_rst_n, 0);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_ce", ce, 0);

    n = 0; while (!pll_rst_n && n < 200) begin step(); n++; end
    chk("pll_rst_low_cycles", n, PRC);
    n = 0; while (sys_rst && n < 3000) begin step(); n++; end
    chk("waitlock_to_run", n, LW + 1);

    first3 = 0; c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int i = 1; i <= 30; i++) begin
      if (ce[3] && first3 == 0) first3 = i;
      c0 += int'(ce[0]); c1 += int'(ce[1]); c2 += int'(ce[2]); c3 += int'(ce[3]);
      step();
    end
    chk("first_ce3_run_cycle", first3, 10);
    chk("ce0_count30", c0, 30);
    chk("ce1_count30", c1, 30);
    chk("ce2_count30", c2, 10);
    chk("ce3_count30", c3, 3);

    n = 0; while (!ce[2] && n < 10) begin step(); n++; end
    gap = 0; step(); gap++; step(); gap++;
    div[47:32] = 16'd5;
    while (!ce[2] && gap < 20) begin step(); gap++; end
    chk("div_change_cur_period", gap, 3);
    gap = 0;
    do begin step(); gap++; end while (!ce[2] && gap < 20);
    chk("div_change_next_period", gap, 5);

    pll_locked = 1'b0;
    n = 0; while (!sys_rst && n < 10) begin step(); n++; end
    chk("lockloss_sys_rst_cycles", n, 3);
    chk("lockloss_ce", ce, 0);
`ifdef CLK_MANAGER_RELOCK_EN
    chk("relock_retry_cnt", retry_cnt, 1);
    n = 0; while (!pll_rst_n && n < 100) begin step(); n++; end
    chk("relock_pll_rst_low", n, PRC);
`else
    chk("lockloss_no_pll_reset", pll_rst_n, 1);
    chk("lockloss_retry_const", retry_cnt, 0);
`endif
    pll_locked = 1'b1;
    step(1100);
    chk("relock_back_in_run", sys_rst, 0);

    reset = 1'b1; step();
    chk("midrun_rst_pll_rst_n", pll_rst_n, 0);
    chk("midrun_rst_sys_rst", sys_rst, 1);
    chk("midrun_rst_ce", ce, 0);
    chk("midrun_rst_lock_sync", lock_sync, 0);
    chk("midrun_rst_retry", retry_cnt, 0);
    chk("midrun_rst_fault", fault, 0);
    reset = 1'b0;

    n = 0; while (!pll_rst_n && n < 200) begin step(); n++; end
    step(501);
    pll_locked = 1'b0; step(); pll_locked = 1'b1;
    n = 0; while (lock_sync && n < 10) begin step(); n++; end
    n = 0; while (!lock_sync && n < 10) begin step(); n++; end
    chk("glitch_lock_sync_low", n, 1);
    n = 0; while (sys_rst && n < 3000) begin step(); n++; end
    chk("glitch_relock_to_run", n, LW + 1);

    pll_locked = 1'b0;
    do_reset();
`ifdef CLK_MANAGER_RELOCK_EN
    n = 0; while (!fault && n < 2000) begin step(); n++; end
    chk("timeout_fault", fault, 1);
    chk("timeout_retry_cnt", retry_cnt, 3);
    step(50);
    chk("fault_pll_rst_n", pll_rst_n, 0);
    chk("fault_sys_rst", sys_rst, 1);
    do_reset();
    chk("fault_cleared_by_reset", fault, 0);
`else
    step(500);
    chk("nolock_no_fault", fault, 0);
    chk("nolock_pll_rst_n", pll_rst_n, 1);
    chk("nolock_sys_rst", sys_rst, 1);
`endif
    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
